// File: rtl/chacha_keygen_pkg.sv
// Shared definitions for the ChaCha20 key generator: FSM states, LFSR
// polynomial, default seed and small helper functions.
package chacha_keygen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    FILL   = 2'd2,
    HOLD   = 2'd3
  } kg_state_e;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_MASK           = 32'h8020_0003;
  localparam logic [31:0] KEYGEN_DEFAULT_SEED = 32'hACE1_2024;

  // Width of a word index for a key of n words (at least one bit)
  function automatic int unsigned kg_idx_width(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

  // One Galois LFSR step
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/keygen_lfsr32.sv
// Free-running 32-bit Galois LFSR with synchronous reseed.
// A zero seed is replaced by SEED so the all-zero lock-up state is unreachable.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (loads SEED)
//   load_i    - load seed_i (or SEED when seed_i is zero) instead of stepping
//   seed_i    - seed value
//   lfsr_o    - current LFSR state
module keygen_lfsr32
  import chacha_keygen_pkg::*;
#(
  parameter logic [31:0] SEED = KEYGEN_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  output logic [31:0] lfsr_o
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  // Step every cycle; a reseed overrides the step
  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
    if (load_i) begin
      lfsr_d = (seed_i == 32'h0) ? SEED : seed_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/chacha_key_gen.sv
// Multi-word key generator: captures NUM_WORDS consecutive LFSR values after
// a warm-up period and offers them as one key on a valid/ready handshake.
// Optional macro KEYGEN_HEALTH_EN adds a repetition-count health test that
// discards a key whose consecutive words repeat and latches health_fail.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - request one key (sampled in IDLE, or on a HOLD transfer)
//   seed_load    - reseed the LFSR and abort any generation
//   seed_in      - seed value
//   key_out      - key, word k at [k*WORD_W +: WORD_W]
//   key_valid    - key_out holds a complete key
//   key_ready    - consumer accepts the key
//   busy         - generator in WARMUP or FILL
//   health_fail  - sticky health-test failure (0 without KEYGEN_HEALTH_EN)
module chacha_key_gen
  import chacha_keygen_pkg::*;
#(
  parameter int unsigned WORD_W        = 32,
  parameter int unsigned NUM_WORDS     = 8,
  parameter int unsigned WARMUP_CYCLES = 64,
  parameter logic [31:0] DEFAULT_SEED  = KEYGEN_DEFAULT_SEED,
  parameter int unsigned CONTINUOUS    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        seed_load,
  input  logic [WORD_W-1:0]           seed_in,
  output logic [WORD_W*NUM_WORDS-1:0] key_out,
  output logic                        key_valid,
  input  logic                        key_ready,
  output logic                        busy,
  output logic                        health_fail
);

  localparam int unsigned KEY_W = WORD_W * NUM_WORDS;
  localparam int unsigned IDX_W = kg_idx_width(NUM_WORDS);
  localparam int unsigned CNT_W = 16;

  kg_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [KEY_W-1:0]   key_q;
  logic               key_valid_q;
  logic               busy_q;
  logic               hf_q;
  logic [WORD_W-1:0]  lfsr_w;
  logic [WORD_W-1:0]  capture_w;
  logic               health_hit;

  keygen_lfsr32 #(
    .SEED (DEFAULT_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (seed_load),
    .seed_i (seed_in),
    .lfsr_o (lfsr_w)
  );

  // FILL stores the value the LFSR takes on this same edge
  assign capture_w = lfsr_step(lfsr_w);

`ifdef KEYGEN_HEALTH_EN
  logic [WORD_W-1:0] prev_q;

  // Repetition test against the previous word of the same key
  assign health_hit = (idx_q != '0) && (capture_w == prev_q);

  always_ff @(posedge clk) begin
    if (rst || seed_load) begin
      prev_q <= '0;
    end else if (state_q == FILL) begin
      prev_q <= capture_w;
    end
  end

  assign health_fail = hf_q;
`else
  assign health_hit  = 1'b0;
  assign health_fail = 1'b0;
`endif

  // Control FSM; seed_load outranks every other event
  always_ff @(posedge clk) begin
    if (rst || seed_load) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      hf_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !hf_q) begin
            state_q <= WARMUP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        WARMUP: begin
          if (cnt_q == CNT_W'(WARMUP_CYCLES - 1)) begin
            state_q <= FILL;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FILL: begin
          if (health_hit) begin
            hf_q    <= 1'b1;
            key_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            key_q[32'(idx_q)*WORD_W +: WORD_W] <= capture_w;
            if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
              idx_q       <= '0;
              key_valid_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= HOLD;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (key_valid_q && key_ready) begin
            key_valid_q <= 1'b0;
            key_q       <= '0;
            idx_q       <= '0;
            if ((CONTINUOUS != 0) || start) begin
              busy_q  <= 1'b1;
              state_q <= FILL;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_out   = key_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_chacha_key_gen.sv
// Randomized self-checking bench for chacha_key_gen with a behavioural
// LFSR/key model. Health-test scenario is built when KEYGEN_HEALTH_EN is set.
module tb_chacha_key_gen;

  localparam int unsigned W     = 4;
  localparam int unsigned N     = 8;
  localparam int unsigned KEY_W = 32 * N;
  localparam logic [31:0] DEF   = 32'hACE1_2024;
  localparam logic [31:0] POLY  = 32'h8020_0003;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             seed_load = 1'b0;
  logic [31:0]      seed_in = '0;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             key_ready = 1'b0;
  logic             busy;
  logic             health_fail;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_lfsr;

  chacha_key_gen #(
    .WORD_W        (32),
    .NUM_WORDS     (N),
    .WARMUP_CYCLES (W),
    .DEFAULT_SEED  (DEF),
    .CONTINUOUS    (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .seed_load   (seed_load),
    .seed_in     (seed_in),
    .key_out     (key_out),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .busy        (busy),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] step(input logic [31:0] x);
    logic [31:0] t;
    t = x >> 1;
    if (x[0]) t = t ^ POLY;
    return t;
  endfunction

  // Reference LFSR: reset / reseed / free-run
  always @(posedge clk) begin
    if (rst) m_lfsr <= DEF;
    else if (seed_load) m_lfsr <= (seed_in == 32'h0) ? DEF : seed_in;
    else m_lfsr <= step(m_lfsr);
  end

  // Key expected from the LFSR value right after the start edge
  function automatic logic [KEY_W-1:0] exp_key(input logic [31:0] l0);
    logic [KEY_W-1:0] k;
    logic [31:0] x;
    k = '0;
    x = l0;
    for (int j = 0; j < int'(W); j++) x = step(x);
    for (int w = 0; w < int'(N); w++) begin
      x = step(x);
      k[w*32 +: 32] = x;
    end
    return k;
  endfunction

  task automatic check(input string tag, input logic [KEY_W-1:0] got,
                       input logic [KEY_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reseed(input logic [31:0] s);
    @(negedge clk);
    seed_load = 1'b1;
    seed_in   = s;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  // Reseed, wait gap cycles, request a key and verify latency/content;
  // optionally pulse start during FILL, which must be ignored.
  task automatic gen_key(input logic [31:0] s, input int gap, input bit pulse_mid,
                         output logic [KEY_W-1:0] k);
    logic [31:0] l0;
    int lat;
    reseed(s);
    repeat (gap) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    l0  = m_lfsr;
    lat = 0;
    check("busy_after_start", KEY_W'(busy), KEY_W'(1));
    while (!key_valid && lat < 300) begin
      start = pulse_mid && (lat == int'(W) + 2);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    k = exp_key(l0);
    check("latency", KEY_W'(lat), KEY_W'(W + N));
    check("key", key_out, k);
    check("word0", KEY_W'(key_out[31:0]), KEY_W'(k[31:0]));
    check("busy_hold", KEY_W'(busy), KEY_W'(0));
  endtask

  // Hold for h cycles, then transfer and confirm return to IDLE
  task automatic drain(input int h, input logic [KEY_W-1:0] k);
    int bad;
    bad = 0;
    repeat (h) begin
      @(negedge clk);
      if (key_out !== k || key_valid !== 1'b1) bad++;
    end
    check("hold_stable", KEY_W'(bad), KEY_W'(0));
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check("xfer_valid", KEY_W'(key_valid), KEY_W'(0));
    check("xfer_zero", key_out, '0);
    bad = 0;
    repeat (W + N + 3) begin
      @(negedge clk);
      if (key_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_after_xfer", KEY_W'(bad), KEY_W'(0));
  endtask

  initial begin
    logic [KEY_W-1:0] k;
    logic [31:0] s;
    int bad;

    // Reset
    repeat (2) @(negedge clk);
    check("rst_key", key_out, '0);
    check("rst_valid", KEY_W'(key_valid), KEY_W'(0));
    check("rst_busy", KEY_W'(busy), KEY_W'(0));
    check("rst_health", KEY_W'(health_fail), KEY_W'(0));
    check("rst_lfsr", KEY_W'(dut.u_lfsr.lfsr_o), KEY_W'(DEF));
    rst = 1'b0;

    // Reseed with 1 and watch the first steps
    @(negedge clk);
    seed_load = 1'b1;
    seed_in   = 32'h1;
    @(negedge clk);
    seed_load = 1'b0;
    check("seed1", KEY_W'(dut.u_lfsr.lfsr_o), KEY_W'(32'h1));
    @(negedge clk);
    check("seed1_step1", KEY_W'(dut.u_lfsr.lfsr_o), KEY_W'(32'h8020_0003));
    @(negedge clk);
    check("seed1_step2", KEY_W'(dut.u_lfsr.lfsr_o), KEY_W'(step(step(32'h1))));
    check("model_sync", KEY_W'(dut.u_lfsr.lfsr_o), KEY_W'(m_lfsr));

    // Directed: seed 1, start the cycle after the load, long hold
    gen_key(32'h1, 0, 1'b0, k);
    drain(20, k);

    // Randomized keys, some with an ignored mid-FILL start
    for (int it = 0; it < 6; it++) begin
      s = $urandom();
      if (it == 3) s = 32'h0;
      gen_key(s, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), k);
      drain(int'($urandom_range(0, 6)), k);
    end

    // Zero-seed abort in the middle of FILL
    reseed($urandom());
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("fill_busy", KEY_W'(busy), KEY_W'(1));
    seed_load = 1'b1;
    seed_in   = 32'h0;
    @(negedge clk);
    seed_load = 1'b0;
    check("abort_busy", KEY_W'(busy), KEY_W'(0));
    check("abort_valid", KEY_W'(key_valid), KEY_W'(0));
    check("abort_lfsr", KEY_W'(dut.u_lfsr.lfsr_o), KEY_W'(DEF));
    bad = 0;
    repeat (W + N + 3) begin
      @(negedge clk);
      if (key_valid !== 1'b0) bad++;
    end
    check("abort_no_key", KEY_W'(bad), KEY_W'(0));

    // seed_load and start together: start dropped
    s = $urandom() | 32'h1;
    @(negedge clk);
    seed_load = 1'b1;
    start     = 1'b1;
    seed_in   = s;
    @(negedge clk);
    seed_load = 1'b0;
    start     = 1'b0;
    check("both_lfsr", KEY_W'(dut.u_lfsr.lfsr_o), KEY_W'(s));
    check("both_busy", KEY_W'(busy), KEY_W'(0));
    bad = 0;
    repeat (W + N + 3) begin
      @(negedge clk);
      if (busy !== 1'b0 || key_valid !== 1'b0) bad++;
    end
    check("both_idle", KEY_W'(bad), KEY_W'(0));

    // key_ready without a key does nothing
    key_ready = 1'b1;
    repeat (3) @(negedge clk);
    key_ready = 1'b0;
    check("ready_idle_valid", KEY_W'(key_valid), KEY_W'(0));
    check("ready_idle_busy", KEY_W'(busy), KEY_W'(0));
    check("lfsr_free_run", KEY_W'(dut.u_lfsr.lfsr_o), KEY_W'(m_lfsr));

`ifdef KEYGEN_HEALTH_EN
    // Stuck LFSR makes consecutive captures equal
    reseed(32'h1357_9BDF);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    force dut.u_lfsr.lfsr_q = 32'h1234_5678;
    bad = 0;
    repeat (W + N + 4) begin
      @(negedge clk);
      if (key_valid !== 1'b0) bad++;
    end
    release dut.u_lfsr.lfsr_q;
    check("hf_no_key", KEY_W'(bad), KEY_W'(0));
    check("hf_set", KEY_W'(health_fail), KEY_W'(1));
    check("hf_key_zero", key_out, '0);
    check("hf_busy", KEY_W'(busy), KEY_W'(0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("hf_start_ignored", KEY_W'(busy), KEY_W'(0));
    reseed(32'h2468_ACE0);
    check("hf_cleared", KEY_W'(health_fail), KEY_W'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
